// File: rtl/wbdemux.sv
// ---------------------------------------------------------------------------
// wbdemux
// Single-master pipelined Wishbone demultiplexer. It sits right after the
// address decoder and uses the decoder's one-hot i_mdecode to steer the
// request to one of NS slaves. A grant is held until every outstanding
// transaction has been answered. Requests decoded to the "no slave" index
// NS are answered locally with a bus error.
//
// Ports
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_mcyc/i_mstb/i_mwe     master cycle, strobe, write enable
//   i_maddr/i_mdata/i_msel  master address, write data, byte selects
//   i_mdecode[NS:0]         one-hot slave decode, bit NS = no slave
//   o_mstall/o_mack/o_merr  stall, ack and error back to the master
//   o_mdata                 read data back to the master
//   o_scyc/o_sstb[NS-1:0]   per-slave cycle and strobe
//   o_swe/o_saddr/o_sdata/o_ssel  broadcast request fields
//   i_sstall/i_sack/i_serr  per-slave stall, ack, error
//   i_sdata[NS*DW-1:0]      per-slave read data, slave k at [k*DW +: DW]
// ---------------------------------------------------------------------------
module wbdemux #(
  parameter int NS           = 4,
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int LGMAXBURST   = 4,
  parameter int OPT_LOWPOWER = 0
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_mcyc,
  input  logic             i_mstb,
  input  logic             i_mwe,
  input  logic [AW-1:0]    i_maddr,
  input  logic [DW-1:0]    i_mdata,
  input  logic [DW/8-1:0]  i_msel,
  input  logic [NS:0]      i_mdecode,
  output logic             o_mstall,
  output logic             o_mack,
  output logic [DW-1:0]    o_mdata,
  output logic             o_merr,
  output logic [NS-1:0]    o_scyc,
  output logic [NS-1:0]    o_sstb,
  output logic             o_swe,
  output logic [AW-1:0]    o_saddr,
  output logic [DW-1:0]    o_sdata,
  output logic [DW/8-1:0]  o_ssel,
  input  logic [NS-1:0]    i_sstall,
  input  logic [NS-1:0]    i_sack,
  input  logic [NS*DW-1:0] i_sdata,
  input  logic [NS-1:0]    i_serr
);

  localparam int IW = $clog2(NS + 1);

  logic                  r_grant_valid;
  logic [IW-1:0]         r_grant_idx;
  logic [LGMAXBURST-1:0] r_nout;
  logic                  r_none_err;

  logic          w_slave_sel;
  logic          w_match;
  logic          w_sel_stall;
  logic          w_sel_ack;
  logic          w_sel_err;
  logic [DW-1:0] w_sel_data;
  logic [IW-1:0] w_new_idx;
  logic          w_accept;
  logic          w_resp;

  // Select the granted slave's response lines; the no-slave index NS
  // selects nothing, so all of these stay zero for it.
  always_comb begin
    w_sel_stall = 1'b0;
    w_sel_ack   = 1'b0;
    w_sel_err   = 1'b0;
    w_sel_data  = '0;
    w_match     = 1'b0;
    w_new_idx   = '0;
    for (int k = 0; k < NS; k++) begin
      if (r_grant_idx == IW'(k)) begin
        w_sel_stall = i_sstall[k];
        w_sel_ack   = i_sack[k];
        w_sel_err   = i_serr[k];
        w_sel_data  = i_sdata[k*DW +: DW];
      end
    end
    for (int k = 0; k <= NS; k++) begin
      if (r_grant_idx == IW'(k))
        w_match = r_grant_valid && i_mdecode[k];
    end
    // Decode is one-hot, so a downward scan simply yields the set bit.
    for (int k = NS; k >= 0; k--) begin
      if (i_mdecode[k])
        w_new_idx = IW'(k);
    end
  end

  assign w_slave_sel = (r_grant_idx < IW'(NS));

  // A pending local error also stalls, limiting the no-slave path to one
  // error every two cycles.
  assign o_mstall = !w_match || (&r_nout) || (w_slave_sel && w_sel_stall) || r_none_err;
  assign w_accept = i_mcyc && i_mstb && !o_mstall;

  always_comb begin
    o_scyc = '0;
    o_sstb = '0;
    for (int k = 0; k < NS; k++) begin
      o_scyc[k] = i_mcyc && r_grant_valid && (r_grant_idx == IW'(k));
      o_sstb[k] = o_scyc[k] && i_mstb && w_match;
    end
  end

  assign o_swe   = i_mwe;
  assign o_saddr = i_maddr;
  assign o_sdata = i_mdata;
  assign o_ssel  = i_msel;

  assign o_mack  = i_mcyc && r_grant_valid && w_slave_sel && w_sel_ack;
  assign o_merr  = i_mcyc && (r_none_err || (r_grant_valid && w_slave_sel && w_sel_err));
  assign o_mdata = ((OPT_LOWPOWER != 0) && !o_mack) ? '0 : w_sel_data;

  assign w_resp  = o_mack || r_none_err;

  // Grant, outstanding counter and local-error state. Dropping the cycle
  // clears everything, so any late responses are simply ignored. The grant
  // may only move once nothing is outstanding.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_nout        <= '0;
      r_none_err    <= 1'b0;
    end else if (!i_mcyc) begin
      r_grant_valid <= 1'b0;
      r_nout        <= '0;
      r_none_err    <= 1'b0;
    end else begin
      r_none_err <= w_accept && (r_grant_idx == IW'(NS));
      if (o_merr)
        r_nout <= '0;
      else if (w_accept && !w_resp)
        r_nout <= r_nout + 1'b1;
      else if (!w_accept && w_resp && (r_nout != '0))
        r_nout <= r_nout - 1'b1;
      if (i_mstb && !w_match && (r_nout == '0) && !r_none_err && (|i_mdecode)) begin
        r_grant_valid <= 1'b1;
        r_grant_idx   <= w_new_idx;
      end
    end
  end

endmodule

// File: tb/tb_wbdemux.sv
// Directed testbench for wbdemux with NS=4, DW=32 and LGMAXBURST=2 so the
// outstanding limit is three transactions.
module tb_wbdemux;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             i_clk = 1'b0;
  logic             i_reset_n;
  logic             i_mcyc, i_mstb, i_mwe;
  logic [AW-1:0]    i_maddr;
  logic [DW-1:0]    i_mdata;
  logic [DW/8-1:0]  i_msel;
  logic [NS:0]      i_mdecode;
  logic             o_mstall, o_mack, o_merr;
  logic [DW-1:0]    o_mdata;
  logic [NS-1:0]    o_scyc, o_sstb;
  logic             o_swe;
  logic [AW-1:0]    o_saddr;
  logic [DW-1:0]    o_sdata;
  logic [DW/8-1:0]  o_ssel;
  logic [NS-1:0]    i_sstall, i_sack, i_serr;
  logic [NS*DW-1:0] i_sdata;

  int nCompared;
  int nMismatched;

  always #5 i_clk = ~i_clk;

  wbdemux #(.NS(NS), .AW(AW), .DW(DW), .LGMAXBURST(2), .OPT_LOWPOWER(0)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_mcyc(i_mcyc), .i_mstb(i_mstb), .i_mwe(i_mwe),
    .i_maddr(i_maddr), .i_mdata(i_mdata), .i_msel(i_msel),
    .i_mdecode(i_mdecode),
    .o_mstall(o_mstall), .o_mack(o_mack), .o_mdata(o_mdata), .o_merr(o_merr),
    .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe),
    .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
    .i_sstall(i_sstall), .i_sack(i_sack), .i_sdata(i_sdata), .i_serr(i_serr)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic go_idle();
    i_mcyc = 1'b0; i_mstb = 1'b0; i_sack = '0; i_serr = '0; i_sstall = '0;
    i_mdecode = '0;
    tick();
  endtask

  task automatic test_reset();
    i_mcyc = 1'b1; i_mstb = 1'b1; i_mdecode = 5'b00010; i_sack = 4'b1111; i_serr = 4'b1111;
    #2;
    nCompared++; if (o_mstall !== 1'b1) begin nMismatched++; $display("[TB] FAIL rst_stall: got %b want 1", o_mstall); end
    nCompared++; if (o_scyc !== 4'b0000) begin nMismatched++; $display("[TB] FAIL rst_scyc: got %b want 0000", o_scyc); end
    nCompared++; if (o_sstb !== 4'b0000) begin nMismatched++; $display("[TB] FAIL rst_sstb: got %b want 0000", o_sstb); end
    nCompared++; if (o_mack !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_mack: got %b want 0", o_mack); end
    nCompared++; if (o_merr !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_merr: got %b want 0", o_merr); end
    i_mwe = 1'b1; i_maddr = 32'h1234_5678; i_mdata = 32'hCAFE_F00D; i_msel = 4'b1010;
    #1;
    nCompared++; if (o_saddr !== 32'h1234_5678 || o_sdata !== 32'hCAFE_F00D || o_ssel !== 4'b1010 || o_swe !== 1'b1) begin
      nMismatched++; $display("[TB] FAIL passthru: got %h %h %b %b want 12345678 cafef00d 1010 1", o_saddr, o_sdata, o_ssel, o_swe); end
    i_mwe = 1'b0;
    go_idle();
    i_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_first_access();
    i_mcyc = 1'b1; i_mstb = 1'b1; i_mdecode = 5'b00010;
    #2;
    nCompared++; if (o_mstall !== 1'b1) begin nMismatched++; $display("[TB] FAIL first_c0_stall: got %b want 1", o_mstall); end
    tick();
    #2;
    nCompared++; if (o_mstall !== 1'b0) begin nMismatched++; $display("[TB] FAIL first_c1_stall: got %b want 0", o_mstall); end
    nCompared++; if (o_sstb !== 4'b0010) begin nMismatched++; $display("[TB] FAIL first_c1_sstb: got %b want 0010", o_sstb); end
    tick();
    i_mstb = 1'b0;
    #2;
    nCompared++; if (dut.r_nout !== 2'd1) begin nMismatched++; $display("[TB] FAIL first_nout1: got %0d want 1", dut.r_nout); end
    nCompared++; if (o_mack !== 1'b0) begin nMismatched++; $display("[TB] FAIL first_c2_mack: got %b want 0", o_mack); end
    tick();
    i_sack = 4'b0010;
    #2;
    nCompared++; if (o_mack !== 1'b1) begin nMismatched++; $display("[TB] FAIL first_c3_mack: got %b want 1", o_mack); end
    nCompared++; if (o_mdata !== 32'hDDDD_0001) begin nMismatched++; $display("[TB] FAIL first_mdata: got %h want dddd0001", o_mdata); end
    tick();
    i_sack = '0;
    #2;
    nCompared++; if (dut.r_nout !== 2'd0) begin nMismatched++; $display("[TB] FAIL first_nout0: got %0d want 0", dut.r_nout); end
    go_idle();
  endtask

  task automatic test_slave_switch();
    i_mcyc = 1'b1; i_mstb = 1'b1; i_mdecode = 5'b00001;
    tick();
    #2;
    nCompared++; if (o_sstb !== 4'b0001) begin nMismatched++; $display("[TB] FAIL sw_sstb0: got %b want 0001", o_sstb); end
    tick();
    tick();
    i_mdecode = 5'b00100;
    #2;
    nCompared++; if (dut.r_nout !== 2'd2) begin nMismatched++; $display("[TB] FAIL sw_nout2: got %0d want 2", dut.r_nout); end
    nCompared++; if (o_mstall !== 1'b1) begin nMismatched++; $display("[TB] FAIL sw_stall_a: got %b want 1", o_mstall); end
    nCompared++; if (o_sstb !== 4'b0000) begin nMismatched++; $display("[TB] FAIL sw_sstb_none: got %b want 0000", o_sstb); end
    tick();
    i_sack = 4'b0001;
    #2;
    nCompared++; if (o_mack !== 1'b1 || o_mstall !== 1'b1) begin nMismatched++; $display("[TB] FAIL sw_ack1: got ack=%b stall=%b want 1 1", o_mack, o_mstall); end
    tick();
    #2;
    nCompared++; if (o_mack !== 1'b1 || o_mstall !== 1'b1) begin nMismatched++; $display("[TB] FAIL sw_ack2: got ack=%b stall=%b want 1 1", o_mack, o_mstall); end
    tick();
    i_sack = '0;
    #2;
    nCompared++; if (o_mstall !== 1'b1) begin nMismatched++; $display("[TB] FAIL sw_switch_stall: got %b want 1", o_mstall); end
    nCompared++; if (o_scyc !== 4'b0001) begin nMismatched++; $display("[TB] FAIL sw_scyc_old: got %b want 0001", o_scyc); end
    tick();
    #2;
    nCompared++; if (o_scyc !== 4'b0100) begin nMismatched++; $display("[TB] FAIL sw_scyc_new: got %b want 0100", o_scyc); end
    nCompared++; if (o_sstb !== 4'b0100 || o_mstall !== 1'b0) begin nMismatched++; $display("[TB] FAIL sw_accept_new: got sstb=%b stall=%b want 0100 0", o_sstb, o_mstall); end
    tick();
    i_mstb = 1'b0; i_sack = 4'b0100;
    #2;
    nCompared++; if (o_mack !== 1'b1 || o_mdata !== 32'hDDDD_0002) begin nMismatched++; $display("[TB] FAIL sw_ack_new: got %b %h want 1 dddd0002", o_mack, o_mdata); end
    go_idle();
  endtask

  task automatic test_no_slave();
    i_mcyc = 1'b1; i_mstb = 1'b1; i_mdecode = 5'b10000;
    #2;
    nCompared++; if (o_mstall !== 1'b1) begin nMismatched++; $display("[TB] FAIL ns_c0_stall: got %b want 1", o_mstall); end
    tick();
    #2;
    nCompared++; if (o_mstall !== 1'b0 || o_sstb !== 4'b0000 || o_scyc !== 4'b0000) begin
      nMismatched++; $display("[TB] FAIL ns_c1: got stall=%b sstb=%b scyc=%b want 0 0000 0000", o_mstall, o_sstb, o_scyc); end
    tick();
    #2;
    nCompared++; if (o_merr !== 1'b1 || o_mack !== 1'b0) begin nMismatched++; $display("[TB] FAIL ns_c2_err: got err=%b ack=%b want 1 0", o_merr, o_mack); end
    nCompared++; if (o_mstall !== 1'b1) begin nMismatched++; $display("[TB] FAIL ns_c2_stall: got %b want 1", o_mstall); end
    tick();
    #2;
    nCompared++; if (o_merr !== 1'b0 || o_mstall !== 1'b0) begin nMismatched++; $display("[TB] FAIL ns_c3: got err=%b stall=%b want 0 0", o_merr, o_mstall); end
    tick();
    i_mstb = 1'b0;
    #2;
    nCompared++; if (o_merr !== 1'b1) begin nMismatched++; $display("[TB] FAIL ns_c4_err: got %b want 1", o_merr); end
    tick();
    #2;
    nCompared++; if (o_merr !== 1'b0 || dut.r_nout !== 2'd0) begin nMismatched++; $display("[TB] FAIL ns_after: got err=%b nout=%0d want 0 0", o_merr, dut.r_nout); end
    go_idle();
  endtask

  task automatic test_outstanding_limit();
    i_mcyc = 1'b1; i_mstb = 1'b1; i_mdecode = 5'b01000;
    tick();
    for (int i = 0; i < 3; i++) begin
      #2;
      nCompared++; if (o_mstall !== 1'b0) begin nMismatched++; $display("[TB] FAIL lim_accept%0d: got stall=%b want 0", i, o_mstall); end
      tick();
    end
    #2;
    nCompared++; if (o_mstall !== 1'b1 || dut.r_nout !== 2'd3) begin nMismatched++; $display("[TB] FAIL lim_full: got stall=%b nout=%0d want 1 3", o_mstall, dut.r_nout); end
    tick();
    i_sack = 4'b1000;
    #2;
    nCompared++; if (o_mack !== 1'b1 || o_mstall !== 1'b1) begin nMismatched++; $display("[TB] FAIL lim_ack_full: got ack=%b stall=%b want 1 1", o_mack, o_mstall); end
    tick();
    #2;
    nCompared++; if (o_mack !== 1'b1 || o_mstall !== 1'b0 || dut.r_nout !== 2'd2) begin
      nMismatched++; $display("[TB] FAIL lim_ack_accept: got ack=%b stall=%b nout=%0d want 1 0 2", o_mack, o_mstall, dut.r_nout); end
    tick();
    i_sack = '0;
    #2;
    nCompared++; if (dut.r_nout !== 2'd2 || o_mstall !== 1'b0) begin nMismatched++; $display("[TB] FAIL lim_same: got nout=%0d stall=%b want 2 0", dut.r_nout, o_mstall); end
    tick();
    #2;
    nCompared++; if (dut.r_nout !== 2'd3 || o_mstall !== 1'b1) begin nMismatched++; $display("[TB] FAIL lim_refull: got nout=%0d stall=%b want 3 1", dut.r_nout, o_mstall); end
    go_idle();
    #2;
    nCompared++; if (dut.r_nout !== 2'd0) begin nMismatched++; $display("[TB] FAIL lim_cyc_drop: got %0d want 0", dut.r_nout); end
  endtask

  task automatic test_slave_error();
    i_mcyc = 1'b1; i_mstb = 1'b1; i_mdecode = 5'b00010;
    tick();
    tick();
    tick();
    i_mstb = 1'b0; i_sack = 4'b0100; i_serr = 4'b1000;
    #2;
    nCompared++; if (o_mack !== 1'b0 || o_merr !== 1'b0) begin nMismatched++; $display("[TB] FAIL err_foreign: got ack=%b err=%b want 0 0", o_mack, o_merr); end
    nCompared++; if (dut.r_nout !== 2'd2) begin nMismatched++; $display("[TB] FAIL err_nout2: got %0d want 2", dut.r_nout); end
    tick();
    i_sack = '0; i_serr = 4'b0010;
    #2;
    nCompared++; if (o_merr !== 1'b1 || o_mack !== 1'b0) begin nMismatched++; $display("[TB] FAIL err_slave: got err=%b ack=%b want 1 0", o_merr, o_mack); end
    tick();
    i_serr = '0;
    #2;
    nCompared++; if (dut.r_nout !== 2'd0) begin nMismatched++; $display("[TB] FAIL err_nout0: got %0d want 0", dut.r_nout); end
    i_mcyc = 1'b0; i_sack = 4'b0010;
    #2;
    nCompared++; if (o_mack !== 1'b0) begin nMismatched++; $display("[TB] FAIL err_late_ack: got %b want 0", o_mack); end
    go_idle();
  endtask

  task automatic test_reset_mid_burst();
    i_mcyc = 1'b1; i_mstb = 1'b1; i_mdecode = 5'b00010;
    tick();
    tick();
    tick();
    tick();
    nCompared++; if (dut.r_nout !== 2'd3) begin nMismatched++; $display("[TB] FAIL mid_nout3: got %0d want 3", dut.r_nout); end
    i_reset_n = 1'b0;
    #1;
    nCompared++; if (dut.r_nout !== 2'd0 || dut.r_grant_valid !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL mid_state: got nout=%0d gv=%b want 0 0", dut.r_nout, dut.r_grant_valid); end
    nCompared++; if (o_scyc !== 4'b0000 || o_mstall !== 1'b1) begin nMismatched++; $display("[TB] FAIL mid_outs: got scyc=%b stall=%b want 0000 1", o_scyc, o_mstall); end
    tick();
    #2;
    nCompared++; if (o_mstall !== 1'b1 || o_sstb !== 4'b0000) begin nMismatched++; $display("[TB] FAIL mid_hold: got stall=%b sstb=%b want 1 0000", o_mstall, o_sstb); end
    go_idle();
    i_reset_n = 1'b1;
    tick();
  endtask

  initial begin
    nCompared = 0; nMismatched = 0;
    i_reset_n = 1'b0; i_mcyc = 1'b0; i_mstb = 1'b0; i_mwe = 1'b0;
    i_maddr = '0; i_mdata = '0; i_msel = '0; i_mdecode = '0;
    i_sstall = '0; i_sack = '0; i_serr = '0;
    i_sdata = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};
    tick();
    test_reset();
    test_first_access();
    test_slave_switch();
    test_no_slave();
    test_outstanding_limit();
    test_slave_error();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
